// File: rtl/sync_fifo_if.sv
// Enable-strobe bus between a producer/consumer and sync_fifo.
// master drives strobes and write data; slave returns read data and flags.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    modport master (
        output w_en,
        output r_en,
        output data_in,
        input  data_out,
        input  full,
        input  empty
    );

    modport slave (
        input  w_en,
        input  r_en,
        input  data_in,
        output data_out,
        output full,
        output empty
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with DEPTH entries and a registered read port.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  full, empty;
    logic                  wr_acc, rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign wr_acc = bus.w_en && !full && !rst_n;
    assign rd_acc = bus.r_en && !empty;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.data_out = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // rst_n is active-high: asserting it clears the pointers at once
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          full;
        logic          empty;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q_m [$];
    logic [DW-1:0] dout_m;
    vec_t          tbl [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: drop writes when full, ignore reads when empty
    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d);
        bit ra, wa;
        ra = r && (q_m.size() > 0);
        wa = w && (q_m.size() < DEPTH);
        if (ra) dout_m = q_m.pop_front();
        if (wa) q_m.push_back(d);
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        model_edge(w, r, d);
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"}, 32'(bus.data_out), 32'(dout_m));
        check({tag, ".full"}, 32'(bus.full), 32'(q_m.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty), 32'(q_m.size() == 0));
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b1;
        #1;
        check({tag, ".rst_empty"}, 32'(bus.empty), 32'd1);
        check({tag, ".rst_full"}, 32'(bus.full), 32'd0);
        check({tag, ".rst_dout"}, 32'(bus.data_out), 32'd0);
        q_m.delete();
        dout_m = '0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        vec_t v;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        dout_m      = '0;
        rst_n       = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            tbl.push_back('{1'b1, 1'b0, 8'(i + 1), 8'h00, 1'(i == DEPTH - 1), 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0});
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back('{1'b0, 1'b1, 8'h00, 8'(i + 1), 1'b0, 1'(i == DEPTH - 1)});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h08, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 8'h33, 8'h08, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b1});

        @(posedge clk);
        #1;
        check("hold_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset.empty", 32'(bus.empty), 32'd1);
        check("reset.full", 32'(bus.full), 32'd0);
        check("reset.dout", 32'(bus.data_out), 32'd0);

        foreach (tbl[i]) begin
            v = tbl[i];
            step(v.w, v.r, v.din);
            check($sformatf("tbl%0d.dout", i), 32'(bus.data_out), 32'(v.dout));
            check($sformatf("tbl%0d.full", i), 32'(bus.full), 32'(v.full));
            check($sformatf("tbl%0d.empty", i), 32'(bus.empty), 32'(v.empty));
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'h50 + i));
            check_model($sformatf("simul%0d", i));
            check($sformatf("simul%0d.occ", i), 32'(q_m.size()), 32'd3);
        end
        while (q_m.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom));
        check_model("prefull");
        step(1'b1, 1'b1, 8'hEE);
        check_model("full_both");
        check("full_both.fullflag", 32'(bus.full), 32'd0);
        while (q_m.size() > 0) begin
            step(1'b0, 1'b1, 8'h00);
            check_model("drain");
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 1'b0, 8'(8'h10 * k + i + 1));
                check_model($sformatf("wrapw%0d_%0d", k, i));
            end
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 1'b1, 8'h00);
                check_model($sformatf("wrapr%0d_%0d", k, i));
            end
        end

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        async_reset("midop");
        step(1'b1, 1'b0, 8'hA5);
        check_model("post_rst_w");
        step(1'b0, 1'b1, 8'h00);
        check_model("post_rst_r");
        check("post_rst_data", 32'(bus.data_out), 32'hA5);

        for (int i = 0; i < 3000; i++) begin
            int wb;
            wb = ((i / 500) % 2 == 0) ? 70 : 30;
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rand_rst");
            end else begin
                step(1'($urandom_range(0, 99) < wb),
                     1'($urandom_range(0, 99) < 100 - wb + 10), 8'($urandom));
                check_model("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
